// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared constants and types for decode_ext_exmem.
//   * opcode / funct field values of the supported instruction subset
//   * ALU control codes (alu_op_e) and immediate-extension codes (ext_op_e)
//   * ex_mem_t: packed bundle of every field held in the EX/MEM register
//   * ext_imm(): immediate extender shared by the top level
package ctrl_pkg;

    // Opcode field values (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Funct field values (instr[5:0]) for R-type
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // jump output encodings
    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_J    = 2'b01;
    localparam logic [1:0] JMP_JAL  = 2'b10;
    localparam logic [1:0] JMP_REG  = 2'b11;

    // Branch output encodings
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_NE   = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_NOR  = 5'd5,
        ALU_SLT  = 5'd6,
        ALU_SLTU = 5'd7,
        ALU_SLL  = 5'd8,
        ALU_SRL  = 5'd9,
        ALU_SRA  = 5'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        EXT_ZERO  = 2'b00,
        EXT_SIGN  = 2'b01,
        EXT_UPPER = 2'b10,
        EXT_ZERO2 = 2'b11
    } ext_op_e;

    // Everything the EX/MEM stage carries forward, in one vector so the
    // register sub-module stays a single load-enabled flop bank.
    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] alu_c;
        logic        zero;
        logic [31:0] rt_data;
        logic [4:0]  reg_rd;
        logic [1:0]  jump;
        logic [1:0]  branch;
        logic        memr;
        logic        memw;
        logic        regw;
        logic        mem2r;
    } ex_mem_t;

    function automatic logic [31:0] ext_imm(input ext_op_e op, input logic [15:0] imm);
        logic [31:0] res;
        case (op)
            EXT_SIGN:  res = {{16{imm[15]}}, imm};
            EXT_UPPER: res = {imm, 16'h0000};
            default:   res = {16'h0000, imm};   // EXT_ZERO and EXT_ZERO2
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// ex_mem_reg -- EX/MEM pipeline register.
//   clk_i   : rising-edge clock
//   rst_n_i : asynchronous active-low reset, clears every field
//   wr_i    : load enable; when low the register holds
//   d_i     : next EX/MEM contents
//   q_o     : registered EX/MEM contents
module ex_mem_reg
    import ctrl_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_n_i,
    input  logic    wr_i,
    input  ex_mem_t d_i,
    output ex_mem_t q_o
);

    ex_mem_t ex_mem_q;
    ex_mem_t ex_mem_d;

    always_comb begin
        ex_mem_d = ex_mem_q;
        if (wr_i) begin
            ex_mem_d = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign q_o = ex_mem_q;

endmodule

// File: rtl/decode_ext_exmem.sv
// decode_ext_exmem -- control decoder, immediate extender and EX/MEM register.
//   clk, rst (async active-low)
//   Decode : OpCode, Funct -> jump, RegDst, Branch, MemR, Mem2R, MemW, RegW,
//            Alusrc, EXTOp, Aluctrl (combinational)
//   Extend : Imm16 -> Imm32 using the decoded EXTOp (combinational)
//   EX/MEM : EX_MEM_WR load enable; *_IN/_in fields registered to *_OUT/_out
// Decode and extend ignore rst; only the EX/MEM fields are reset.
module decode_ext_exmem
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    // decode
    input  logic [5:0]  OpCode,
    input  logic [5:0]  Funct,
    output logic [1:0]  jump,
    output logic        RegDst,
    output logic [1:0]  Branch,
    output logic        MemR,
    output logic        Mem2R,
    output logic        MemW,
    output logic        RegW,
    output logic        Alusrc,
    output logic [1:0]  EXTOp,
    output logic [4:0]  Aluctrl,
    // extender
    input  logic [15:0] Imm16,
    output logic [31:0] Imm32,
    // EX/MEM register
    input  logic        EX_MEM_WR,
    input  logic [31:0] NPC_IN,
    output logic [31:0] NPC_OUT,
    input  logic [31:0] ALU_C_IN,
    output logic [31:0] ALU_C_OUT,
    input  logic        ZERO_IN,
    output logic        ZERO_OUT,
    input  logic [31:0] RT_DATA_IN,
    output logic [31:0] RT_DATA_OUT,
    input  logic [4:0]  reg_rd_in,
    output logic [4:0]  reg_rd_out,
    input  logic [1:0]  jump_in,
    output logic [1:0]  jump_out,
    input  logic [1:0]  Branch_IN,
    output logic [1:0]  Branch_OUT,
    input  logic        MEMR_IN,
    output logic        MEMR_OUT,
    input  logic        MEMW_IN,
    output logic        MEMW_OUT,
    input  logic        REGW_IN,
    output logic        REGW_OUT,
    input  logic        MEM2R_IN,
    output logic        MEM2R_OUT
);

    alu_op_e alu_sel;
    ext_op_e ext_sel;

    // ---------------- decode ----------------
    always_comb begin
        jump    = JMP_NONE;
        RegDst  = 1'b0;
        Branch  = BR_NONE;
        MemR    = 1'b0;
        Mem2R   = 1'b0;
        MemW    = 1'b0;
        RegW    = 1'b0;
        Alusrc  = 1'b0;
        ext_sel = EXT_ZERO;
        alu_sel = ALU_ADD;

        case (OpCode)
            OP_RTYPE: begin
                RegW = 1'b1;
                case (Funct)
                    FN_ADD, FN_ADDU: alu_sel = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_sel = ALU_SUB;
                    FN_AND:          alu_sel = ALU_AND;
                    FN_OR:           alu_sel = ALU_OR;
                    FN_XOR:          alu_sel = ALU_XOR;
                    FN_NOR:          alu_sel = ALU_NOR;
                    FN_SLT:          alu_sel = ALU_SLT;
                    FN_SLTU:         alu_sel = ALU_SLTU;
                    FN_SLL:          alu_sel = ALU_SLL;
                    FN_SRL:          alu_sel = ALU_SRL;
                    FN_SRA:          alu_sel = ALU_SRA;
                    FN_JR: begin
                        RegW = 1'b0;
                        jump = JMP_REG;
                    end
                    // unknown funct is a NOP: undo the R-type write enable
                    default:         RegW = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                RegW   = 1'b1;
                RegDst = 1'b1;
                Alusrc = 1'b1;
                case (OpCode)
                    OP_SLTI: begin ext_sel = EXT_SIGN;  alu_sel = ALU_SLT; end
                    OP_ANDI: begin ext_sel = EXT_ZERO;  alu_sel = ALU_AND; end
                    OP_ORI:  begin ext_sel = EXT_ZERO;  alu_sel = ALU_OR;  end
                    OP_XORI: begin ext_sel = EXT_ZERO;  alu_sel = ALU_XOR; end
                    OP_LUI:  begin ext_sel = EXT_UPPER; alu_sel = ALU_ADD; end
                    default: begin ext_sel = EXT_SIGN;  alu_sel = ALU_ADD; end
                endcase
            end
            OP_LW: begin
                MemR    = 1'b1;
                Mem2R   = 1'b1;
                RegW    = 1'b1;
                RegDst  = 1'b1;
                Alusrc  = 1'b1;
                ext_sel = EXT_SIGN;
                alu_sel = ALU_ADD;
            end
            OP_SW: begin
                MemW    = 1'b1;
                Alusrc  = 1'b1;
                ext_sel = EXT_SIGN;
                alu_sel = ALU_ADD;
            end
            OP_BEQ: begin
                Branch  = BR_EQ;
                ext_sel = EXT_SIGN;
                alu_sel = ALU_SUB;
            end
            OP_BNE: begin
                Branch  = BR_NE;
                ext_sel = EXT_SIGN;
                alu_sel = ALU_SUB;
            end
            OP_J: begin
                Branch = BR_JMP;
                jump   = JMP_J;
            end
            OP_JAL: begin
                Branch = BR_JMP;
                jump   = JMP_JAL;
                RegW   = 1'b1;
            end
            default: ;
        endcase
    end

    assign EXTOp   = ext_sel;
    assign Aluctrl = alu_sel;

    // ---------------- extender ----------------
    assign Imm32 = ext_imm(ext_sel, Imm16);

    // ---------------- EX/MEM register ----------------
    ex_mem_t ex_mem_in;
    ex_mem_t ex_mem_out;

    assign ex_mem_in = '{
        npc:     NPC_IN,
        alu_c:   ALU_C_IN,
        zero:    ZERO_IN,
        rt_data: RT_DATA_IN,
        reg_rd:  reg_rd_in,
        jump:    jump_in,
        branch:  Branch_IN,
        memr:    MEMR_IN,
        memw:    MEMW_IN,
        regw:    REGW_IN,
        mem2r:   MEM2R_IN
    };

    ex_mem_reg u_ex_mem_reg (
        .clk_i   (clk),
        .rst_n_i (rst),
        .wr_i    (EX_MEM_WR),
        .d_i     (ex_mem_in),
        .q_o     (ex_mem_out)
    );

    assign NPC_OUT     = ex_mem_out.npc;
    assign ALU_C_OUT   = ex_mem_out.alu_c;
    assign ZERO_OUT    = ex_mem_out.zero;
    assign RT_DATA_OUT = ex_mem_out.rt_data;
    assign reg_rd_out  = ex_mem_out.reg_rd;
    assign jump_out    = ex_mem_out.jump;
    assign Branch_OUT  = ex_mem_out.branch;
    assign MEMR_OUT    = ex_mem_out.memr;
    assign MEMW_OUT    = ex_mem_out.memw;
    assign REGW_OUT    = ex_mem_out.regw;
    assign MEM2R_OUT   = ex_mem_out.mem2r;

endmodule

// File: tb/tb_decode_ext_exmem.sv
// tb_decode_ext_exmem -- self-checking bench for decode_ext_exmem.
// Expected results are queued when stimulus is driven and popped when the
// DUT output is sampled (#1 after a drive or after a rising edge).
module tb_decode_ext_exmem;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  OpCode, Funct;
    logic [1:0]  jump, Branch, EXTOp;
    logic        RegDst, MemR, Mem2R, MemW, RegW, Alusrc;
    logic [4:0]  Aluctrl;
    logic [15:0] Imm16;
    logic [31:0] Imm32;
    logic        EX_MEM_WR;
    logic [31:0] NPC_IN, NPC_OUT, ALU_C_IN, ALU_C_OUT, RT_DATA_IN, RT_DATA_OUT;
    logic        ZERO_IN, ZERO_OUT;
    logic [4:0]  reg_rd_in, reg_rd_out;
    logic [1:0]  jump_in, jump_out, Branch_IN, Branch_OUT;
    logic        MEMR_IN, MEMR_OUT, MEMW_IN, MEMW_OUT, REGW_IN, REGW_OUT, MEM2R_IN, MEM2R_OUT;

    always #5 clk = ~clk;

    decode_ext_exmem dut (
        .clk(clk), .rst(rst),
        .OpCode(OpCode), .Funct(Funct),
        .jump(jump), .RegDst(RegDst), .Branch(Branch), .MemR(MemR), .Mem2R(Mem2R),
        .MemW(MemW), .RegW(RegW), .Alusrc(Alusrc), .EXTOp(EXTOp), .Aluctrl(Aluctrl),
        .Imm16(Imm16), .Imm32(Imm32),
        .EX_MEM_WR(EX_MEM_WR),
        .NPC_IN(NPC_IN), .NPC_OUT(NPC_OUT),
        .ALU_C_IN(ALU_C_IN), .ALU_C_OUT(ALU_C_OUT),
        .ZERO_IN(ZERO_IN), .ZERO_OUT(ZERO_OUT),
        .RT_DATA_IN(RT_DATA_IN), .RT_DATA_OUT(RT_DATA_OUT),
        .reg_rd_in(reg_rd_in), .reg_rd_out(reg_rd_out),
        .jump_in(jump_in), .jump_out(jump_out),
        .Branch_IN(Branch_IN), .Branch_OUT(Branch_OUT),
        .MEMR_IN(MEMR_IN), .MEMR_OUT(MEMR_OUT),
        .MEMW_IN(MEMW_IN), .MEMW_OUT(MEMW_OUT),
        .REGW_IN(REGW_IN), .REGW_OUT(REGW_OUT),
        .MEM2R_IN(MEM2R_IN), .MEM2R_OUT(MEM2R_OUT)
    );

    int vec_cnt = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Decode word layout: {jump, RegDst, Branch, MemR, Mem2R, MemW, RegW, Alusrc, EXTOp, Aluctrl}
    function automatic logic [16:0] ctl(input logic [1:0] j, input logic rd, input logic [1:0] br,
                                        input logic mr, input logic m2r, input logic mw,
                                        input logic rw, input logic as, input logic [1:0] ext,
                                        input logic [4:0] alu);
        return {j, rd, br, mr, m2r, mw, rw, as, ext, alu};
    endfunction

    function automatic logic [16:0] dec_obs();
        return {jump, RegDst, Branch, MemR, Mem2R, MemW, RegW, Alusrc, EXTOp, Aluctrl};
    endfunction

    function automatic logic [109:0] reg_obs();
        return {NPC_OUT, ALU_C_OUT, ZERO_OUT, RT_DATA_OUT, reg_rd_out, jump_out,
                Branch_OUT, MEMR_OUT, MEMW_OUT, REGW_OUT, MEM2R_OUT};
    endfunction

    function automatic logic [109:0] reg_in();
        return {NPC_IN, ALU_C_IN, ZERO_IN, RT_DATA_IN, reg_rd_in, jump_in,
                Branch_IN, MEMR_IN, MEMW_IN, REGW_IN, MEM2R_IN};
    endfunction

    typedef struct {
        string       tag;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [16:0] ctrl;
        logic [31:0] imm32;
    } dvec_t;

    dvec_t       dv[$];
    logic [48:0] dec_exp_q[$];     // {ctrl, imm32}
    logic [109:0] reg_exp_q[$];
    logic [48:0] dpop;
    logic [109:0] rpop;
    logic [109:0] held;

    task automatic apply_dec(input dvec_t v);
        OpCode = v.op;
        Funct  = v.fn;
        Imm16  = v.imm;
        dec_exp_q.push_back({v.ctrl, v.imm32});
        #1;
        dpop = dec_exp_q.pop_front();
        check_eq({v.tag, ".ctrl"}, 128'(dec_obs()), 128'(dpop[48:32]));
        check_eq({v.tag, ".imm32"}, 128'(Imm32), 128'(dpop[31:0]));
    endtask

    task automatic rand_reg_inputs();
        NPC_IN     = $urandom;
        ALU_C_IN   = $urandom;
        ZERO_IN    = 1'($urandom);
        RT_DATA_IN = $urandom;
        reg_rd_in  = 5'($urandom);
        jump_in    = 2'($urandom);
        Branch_IN  = 2'($urandom);
        MEMR_IN    = 1'($urandom);
        MEMW_IN    = 1'($urandom);
        REGW_IN    = 1'($urandom);
        MEM2R_IN   = 1'($urandom);
    endtask

    initial begin
        rst = 1'b0;
        EX_MEM_WR = 1'b0;
        OpCode = '0; Funct = '0; Imm16 = '0;
        rand_reg_inputs();

        //            tag        op     fn     imm        j  rd br mr m2 mw rw as ext alu   imm32
        dv.push_back('{"lw",    6'h23, 6'h00, 16'h8004, ctl(0,1,0,1,1,0,1,1,1,0),  32'hFFFF8004});
        dv.push_back('{"slt",   6'h00, 6'h2A, 16'h1234, ctl(0,0,0,0,0,0,1,0,0,6),  32'h00001234});
        dv.push_back('{"jr",    6'h00, 6'h08, 16'h1234, ctl(3,0,0,0,0,0,0,0,0,0),  32'h00001234});
        dv.push_back('{"op3f",  6'h3F, 6'h20, 16'h8004, ctl(0,0,0,0,0,0,0,0,0,0),  32'h00008004});
        dv.push_back('{"addi",  6'h08, 6'h00, 16'h8004, ctl(0,1,0,0,0,0,1,1,1,0),  32'hFFFF8004});
        dv.push_back('{"ori",   6'h0D, 6'h00, 16'h8004, ctl(0,1,0,0,0,0,1,1,0,3),  32'h00008004});
        dv.push_back('{"lui",   6'h0F, 6'h00, 16'h8004, ctl(0,1,0,0,0,0,1,1,2,0),  32'h80040000});
        dv.push_back('{"addiu", 6'h09, 6'h00, 16'h7FFF, ctl(0,1,0,0,0,0,1,1,1,0),  32'h00007FFF});
        dv.push_back('{"slti",  6'h0A, 6'h00, 16'h8000, ctl(0,1,0,0,0,0,1,1,1,6),  32'hFFFF8000});
        dv.push_back('{"andi",  6'h0C, 6'h00, 16'hF00F, ctl(0,1,0,0,0,0,1,1,0,2),  32'h0000F00F});
        dv.push_back('{"xori",  6'h0E, 6'h00, 16'h00FF, ctl(0,1,0,0,0,0,1,1,0,4),  32'h000000FF});
        dv.push_back('{"sw",    6'h2B, 6'h00, 16'hFFFC, ctl(0,0,0,0,0,1,0,1,1,0),  32'hFFFFFFFC});
        dv.push_back('{"beq",   6'h04, 6'h00, 16'hFFFE, ctl(0,0,1,0,0,0,0,0,1,1),  32'hFFFFFFFE});
        dv.push_back('{"bne",   6'h05, 6'h00, 16'h0010, ctl(0,0,2,0,0,0,0,0,1,1),  32'h00000010});
        dv.push_back('{"j",     6'h02, 6'h00, 16'h8000, ctl(1,0,3,0,0,0,0,0,0,0),  32'h00008000});
        dv.push_back('{"jal",   6'h03, 6'h00, 16'h8000, ctl(2,0,3,0,0,0,1,0,0,0),  32'h00008000});
        dv.push_back('{"add",   6'h00, 6'h20, 16'h0001, ctl(0,0,0,0,0,0,1,0,0,0),  32'h00000001});
        dv.push_back('{"subu",  6'h00, 6'h23, 16'h0001, ctl(0,0,0,0,0,0,1,0,0,1),  32'h00000001});
        dv.push_back('{"nor",   6'h00, 6'h27, 16'h0001, ctl(0,0,0,0,0,0,1,0,0,5),  32'h00000001});
        dv.push_back('{"sltu",  6'h00, 6'h2B, 16'h0001, ctl(0,0,0,0,0,0,1,0,0,7),  32'h00000001});
        dv.push_back('{"sll",   6'h00, 6'h00, 16'h0001, ctl(0,0,0,0,0,0,1,0,0,8),  32'h00000001});
        dv.push_back('{"srl",   6'h00, 6'h02, 16'h0001, ctl(0,0,0,0,0,0,1,0,0,9),  32'h00000001});
        dv.push_back('{"sra",   6'h00, 6'h03, 16'h0001, ctl(0,0,0,0,0,0,1,0,0,10), 32'h00000001});
        dv.push_back('{"rbad",  6'h00, 6'h3F, 16'h8001, ctl(0,0,0,0,0,0,0,0,0,0),  32'h00008001});

        // reset state while rst is held low (also checks decode ignores rst)
        #12;
        check_eq("reset_regs", 128'(reg_obs()), 128'(110'd0));
        apply_dec(dv[0]);

        @(negedge clk);
        rst = 1'b1;
        foreach (dv[i]) apply_dec(dv[i]);

        // load with EX_MEM_WR=1
        @(negedge clk);
        rand_reg_inputs();
        NPC_IN = 32'h0000_3010;
        reg_rd_in = 5'd5;
        EX_MEM_WR = 1'b1;
        reg_exp_q.push_back(reg_in());
        @(posedge clk); #1;
        rpop = reg_exp_q.pop_front();
        check_eq("load.all", 128'(reg_obs()), 128'(rpop));
        check_eq("load.npc", 128'(NPC_OUT), 128'(32'h0000_3010));
        check_eq("load.rd", 128'(reg_rd_out), 128'(5'd5));
        held = rpop;

        // inputs changing between edges must not reach the outputs
        rand_reg_inputs();
        #2;
        check_eq("midcycle.hold", 128'(reg_obs()), 128'(held));

        // EX_MEM_WR=0 with new inputs: hold
        @(negedge clk);
        EX_MEM_WR = 1'b0;
        rand_reg_inputs();
        reg_exp_q.push_back(held);
        @(posedge clk); #1;
        rpop = reg_exp_q.pop_front();
        check_eq("hold.all", 128'(reg_obs()), 128'(rpop));
        check_eq("hold.npc", 128'(NPC_OUT), 128'(32'h0000_3010));
        check_eq("hold.rd", 128'(reg_rd_out), 128'(5'd5));

        // random mix of loads and holds
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            rand_reg_inputs();
            EX_MEM_WR = 1'($urandom);
            if (EX_MEM_WR) held = reg_in();
            reg_exp_q.push_back(held);
            @(posedge clk); #1;
            rpop = reg_exp_q.pop_front();
            check_eq($sformatf("mix%0d.wr%0d", k, EX_MEM_WR), 128'(reg_obs()), 128'(rpop));
        end

        // make sure something nonzero is held before the reset pulse
        @(negedge clk);
        rand_reg_inputs();
        NPC_IN = 32'hDEAD_BEEF;
        EX_MEM_WR = 1'b1;
        @(posedge clk); #1;
        check_eq("preload.npc", 128'(NPC_OUT), 128'(32'hDEAD_BEEF));

        // async reset pulse between edges
        EX_MEM_WR = 1'b0;
        #1 rst = 1'b0;
        #1;
        check_eq("async_rst.regs", 128'(reg_obs()), 128'(110'd0));
        apply_dec(dv[6]);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst.hold0", 128'(reg_obs()), 128'(110'd0));

        // first qualifying edge after reset loads again
        @(negedge clk);
        rand_reg_inputs();
        EX_MEM_WR = 1'b1;
        reg_exp_q.push_back(reg_in());
        @(posedge clk); #1;
        rpop = reg_exp_q.pop_front();
        check_eq("post_rst.load", 128'(reg_obs()), 128'(rpop));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_ext_exmem.md
DECODE_EXT_EXMEM -- requirements
Module: decode_ext_exmem

Interface
REQ-001 The block SHALL have no parameters; widths are fixed as listed below.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
REQ-003 Decode ports SHALL be:
- OpCode  in  6  instr[31:26].
- Funct  in  6  instr[5:0].
- jump  out  2.
- RegDst  out  1  1 = write rt, 0 = write rd.
- Branch  out  2.
- MemR, Mem2R, MemW, RegW, Alusrc  out  1 each.
- EXTOp  out  2.
- Aluctrl  out  5.
REQ-004 Extender ports SHALL be:
- Imm16  in  16.
- Imm32  out  32  extended immediate, selected by the internal EXTOp.
REQ-005 EX/MEM register ports SHALL be:
- EX_MEM_WR  in  1  load enable.
- NPC_IN / NPC_OUT  32  branch target.
- ALU_C_IN / ALU_C_OUT  32.
- ZERO_IN / ZERO_OUT  1.
- RT_DATA_IN / RT_DATA_OUT  32.
- reg_rd_in / reg_rd_out  5.
- jump_in / jump_out  2.
- Branch_IN / Branch_OUT  2.
- MEMR_IN/OUT, MEMW_IN/OUT, REGW_IN/OUT, MEM2R_IN/OUT  1 each.

Function
REQ-006 Decode and extend SHALL be purely combinational with zero latency; only the EX/MEM fields are registered.
REQ-007 Aluctrl encoding SHALL be:
- ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5.
- SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10.
REQ-008 Decode defaults SHALL be all outputs 0; any unlisted OpCode/Funct SHALL decode as a NOP with all outputs 0.
REQ-009 R-type (OpCode 0x00) SHALL set RegW=1, RegDst=0, Alusrc=0, with Funct mapping:
- 0x20/0x21 -> ADD; 0x22/0x23 -> SUB.
- 0x24 -> AND; 0x25 -> OR; 0x26 -> XOR; 0x27 -> NOR.
- 0x2A -> SLT; 0x2B -> SLTU.
- 0x00 -> SLL; 0x02 -> SRL; 0x03 -> SRA.
REQ-010 Funct 0x08 (jr) SHALL set jump=11, Branch=00 and RegW=0.
REQ-011 ALU-immediate instructions SHALL set RegW=1, RegDst=1, Alusrc=1, with:
- addi 0x08 / addiu 0x09 -> EXTOp=01, ADD.
- slti 0x0A -> EXTOp=01, SLT.
- andi 0x0C -> EXTOp=00, AND.
- ori 0x0D -> EXTOp=00, OR.
- xori 0x0E -> EXTOp=00, XOR.
- lui 0x0F -> EXTOp=10, ADD.
REQ-012 Memory instructions SHALL decode as:
- lw 0x23 -> MemR=1, Mem2R=1, RegW=1, RegDst=1, Alusrc=1, EXTOp=01, ADD.
- sw 0x2B -> MemW=1, Alusrc=1, EXTOp=01, ADD.
REQ-013 Branch instructions SHALL decode as:
- beq 0x04 -> Branch=01, EXTOp=01, SUB.
- bne 0x05 -> Branch=10, EXTOp=01, SUB.
REQ-014 Jump instructions SHALL decode as:
- j 0x02 -> Branch=11, jump=01.
- jal 0x03 -> Branch=11, jump=10, RegW=1.
REQ-015 EXT SHALL produce, by EXTOp:
- 00 -> {16'h0, Imm16}.
- 01 -> sign-extend Imm16[15].
- 10 -> {Imm16, 16'h0}.
- 11 -> zero-extend.
REQ-016 On each rising clk edge with rst high and EX_MEM_WR=1, every *_OUT/_out SHALL load its corresponding input.
REQ-017 With EX_MEM_WR=0, all registered outputs SHALL hold their values.
REQ-018 Registered outputs SHALL change only on a clk edge or on reset; inputs changing between edges SHALL have no effect.

Reset
REQ-019 While rst=0, all registered outputs SHALL be 0 immediately, independent of clk, and SHALL stay 0 until the first qualifying edge after rst returns to 1.
REQ-020 Asserting reset mid-operation SHALL discard the held contents; decode and EXT outputs SHALL be unaffected by rst.

Structure
REQ-021 Opcode constants, Funct constants, Aluctrl codes and EXTOp codes SHALL reside in a shared package (ctrl_pkg).
REQ-022 The EX/MEM pipeline register SHALL be one natural sub-module (ex_mem_reg); decode and EXT SHALL remain in the top.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- OpCode=0x23 -> MemR=Mem2R=RegW=RegDst=Alusrc=1, EXTOp=01, Aluctrl=0, all other outputs 0.
- OpCode=0x00, Funct=0x2A -> RegW=1, RegDst=0, Aluctrl=6.
- OpCode=0x00, Funct=0x08 -> jump=11, RegW=0.
- OpCode=0x3F -> all decode outputs 0.
- Imm16=0x8004 with OpCode 0x08 / 0x0D / 0x0F -> Imm32 = 0xFFFF8004 / 0x00008004 / 0x80040000.
- EX_MEM_WR=1, NPC_IN=0x00003010, reg_rd_in=5 -> outputs updated after the edge.
- Then EX_MEM_WR=0 with new inputs -> outputs hold 0x00003010 / 5.
- Pulse rst low between edges -> all registered outputs 0 immediately, before any clk edge.
